// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline controller: forwarding select
// encoding, shadow scoreboard entry and the hazard-match helper.
package riscv_pipe_pkg;

    // Scoreboard register fields are stored at a fixed width wide enough for
    // any REG_ADDR_W the core uses; the top zero-extends its indices.
    localparam int PIPE_RW = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [PIPE_RW-1:0] rd;
        logic [PIPE_RW-1:0] rs1;
        logic [PIPE_RW-1:0] rs2;
        logic               use1;
        logic               use2;
        logic               reg_write;
        logic               mem_read;
        logic               mem_op;
    } pipe_entry_t;

    localparam pipe_entry_t PIPE_NOP = '0;

    // A producer entry hits a consumer source when it really writes a
    // non-zero rd equal to a source the consumer actually reads.
    function automatic logic reg_hit(pipe_entry_t e, logic [PIPE_RW-1:0] r, logic used);
        return used && e.valid && e.reg_write && (e.rd != '0) && (e.rd == r);
    endfunction

endpackage

// File: rtl/riscv_mem_wait_ctr.sv
// Data-memory wait-state counter: holds the pipeline for MEM_LAT-1 cycles
// while a load/store occupies MEM, then lets it leave on the following cycle.
module riscv_mem_wait_ctr #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_busy,
    output logic freeze_mem
);

    localparam int         LAST_I = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [3:0] LAST   = 4'(LAST_I);

    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    // done_q marks that the current MEM op has served its wait states, so the
    // next cycle is its release cycle and the pipeline may advance.
    always_comb begin
        freeze_mem = (MEM_LAT > 1) && !reset && mem_busy && !done_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        if (freeze_mem) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + 4'd1;
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Hazard / pipeline controller for the 5-stage RISC-V core. Tracks a shadow
// copy of EX/MEM/WB destination info and drives stall, flush, freeze and
// forwarding selects for the datapath.
module riscv_pipe_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  ex_branch_taken,
    output logic                  stall_fetch,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic                  freeze_mem,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_e;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic hazard;
    fwd_sel_e fwd_a, fwd_b;

    riscv_mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk        (clk),
        .reset      (reset),
        .mem_busy   (mem_q.valid && mem_q.mem_op),
        .freeze_mem (freeze_mem)
    );

    // Pack the ID instruction into a scoreboard entry.
    always_comb begin
        id_e           = PIPE_NOP;
        id_e.valid     = id_valid;
        id_e.rd        = PIPE_RW'(id_rd);
        id_e.rs1       = PIPE_RW'(id_rs1);
        id_e.rs2       = PIPE_RW'(id_rs2);
        id_e.use1      = id_use_rs1;
        id_e.use2      = id_use_rs2;
        id_e.reg_write = id_reg_write;
        id_e.mem_read  = id_mem_read;
        id_e.mem_op    = id_mem_read || id_mem_write;
    end

    // Data-hazard detect: with forwarding only a load in EX must stall; without
    // it any in-flight producer of a used source interlocks.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = ex_q.mem_read &&
                     (reg_hit(ex_q, id_e.rs1, id_use_rs1) || reg_hit(ex_q, id_e.rs2, id_use_rs2));
        end else begin
            hazard = reg_hit(ex_q,  id_e.rs1, id_use_rs1) || reg_hit(ex_q,  id_e.rs2, id_use_rs2) ||
                     reg_hit(mem_q, id_e.rs1, id_use_rs1) || reg_hit(mem_q, id_e.rs2, id_use_rs2) ||
                     reg_hit(wb_q,  id_e.rs1, id_use_rs1) || reg_hit(wb_q,  id_e.rs2, id_use_rs2);
        end
        hazard = hazard && id_valid;
    end

    // Stall/flush with priority reset > freeze > branch flush > data stall.
    always_comb begin
        flush_if_id  = !reset && !freeze_mem && ex_branch_taken;
        stall_fetch  = !reset && !freeze_mem && !flush_if_id && hazard;
        bubble_id_ex = flush_if_id || stall_fetch;
    end

    // Forwarding decode from registered state only; MEM beats WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0 && !reset) begin
            if (reg_hit(mem_q, ex_q.rs1, ex_q.valid && ex_q.use1))     fwd_a = FWD_MEM;
            else if (reg_hit(wb_q, ex_q.rs1, ex_q.valid && ex_q.use1)) fwd_a = FWD_WB;
            if (reg_hit(mem_q, ex_q.rs2, ex_q.valid && ex_q.use2))     fwd_b = FWD_MEM;
            else if (reg_hit(wb_q, ex_q.rs2, ex_q.valid && ex_q.use2)) fwd_b = FWD_WB;
        end
        fwd_a_sel = fwd_a;
        fwd_b_sel = fwd_b;
    end

    // Shadow pipeline advance and saturating stall counter next state.
    always_comb begin
        ex_d           = ex_q;
        mem_d          = mem_q;
        wb_d           = PIPE_NOP;
        stall_cycles_d = stall_cycles_q;
        if (!freeze_mem) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = bubble_id_ex ? PIPE_NOP : id_e;
        end
        if ((stall_fetch || freeze_mem) && stall_cycles_q != CNT_MAX)
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= PIPE_NOP;
            mem_q          <= PIPE_NOP;
            wb_q           <= PIPE_NOP;
            stall_cycles_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: three instances share one stimulus
// stream (forwarding/1-cycle MEM, forwarding/3-cycle MEM, interlock/4-bit
// counter); each scenario resets and checks the instance it targets.
module tb_riscv_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken;

    logic        s0, f0, b0, z0;  logic [1:0] fa0, fb0; logic [15:0] c0;
    logic        s1, f1, b1, z1;  logic [1:0] fa1, fb1; logic [15:0] c1;
    logic        s2, f2, b2, z2;  logic [1:0] fa2, fb2; logic [3:0]  c2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    riscv_pipe_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1), .FWD_EN(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken),
        .stall_fetch(s0), .flush_if_id(f0), .bubble_id_ex(b0), .freeze_mem(z0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cycles(c0));

    riscv_pipe_ctrl #(.REG_ADDR_W(5), .MEM_LAT(3), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken),
        .stall_fetch(s1), .flush_if_id(f1), .bubble_id_ex(b1), .freeze_mem(z1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cycles(c1));

    riscv_pipe_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1), .FWD_EN(0), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_branch_taken(ex_branch_taken),
        .stall_fetch(s2), .flush_if_id(f2), .bubble_id_ex(b2), .freeze_mem(z2),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cycles(c2));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive an ID instruction: valid, rs1, rs2, use1, use2, rd, reg_write, load, store.
    task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                          input logic u2, input int rd, input logic rw, input logic mr,
                          input logic mw);
        id_valid = v;  id_rs1 = 5'(rs1);  id_rs2 = 5'(rs2);
        id_use_rs1 = u1;  id_use_rs2 = u2;  id_rd = 5'(rd);
        id_reg_write = rw;  id_mem_read = mr;  id_mem_write = mw;
    endtask

    task automatic id_nop();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are set 1 time unit after the edge; checks happen mid-cycle.
    task automatic mid();
        #4;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b1;
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        mid();
        chk("rst_flush", f0, 0);
        chk("rst_bubble", b0, 0);
        next();
        next();
        reset = 1'b0;
        ex_branch_taken = 1'b0;
        id_nop();
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        id_nop();
        next();

        // 1. load-use: one stall, then WB forwarding on operand A
        do_reset();
        chk("rst_cnt", c0, 0);
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0);          // lw x5
        mid(); chk("lu_c0_stall", s0, 0); next();
        set_id(1'b1, 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);          // add x6,x5,x1
        mid(); chk("lu_stall", s0, 1); chk("lu_bubble", b0, 1); next();
        mid(); chk("lu_stall_once", s0, 0); next();
        id_nop();
        mid(); chk("lu_fwd_a", fa0, 2); chk("lu_fwd_b", fb0, 0); chk("lu_cnt", c0, 1); next();

        // 2. ALU back-to-back: no stall, EX/MEM forwarding on both operands
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);          // add x5,x1,x2
        mid(); next();
        set_id(1'b1, 5, 5, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);          // sub x7,x5,x5
        mid(); chk("alu_no_stall", s0, 0); next();
        id_nop();
        mid(); chk("alu_fwd_a", fa0, 1); chk("alu_fwd_b", fb0, 1); chk("nofwd_sel_a", fa2, 0); next();

        // 3. taken branch beats a simultaneous load-use stall
        do_reset();
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0);          // lw x5
        mid(); next();
        set_id(1'b1, 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        ex_branch_taken = 1'b1;
        mid(); chk("br_flush", f0, 1); chk("br_bubble", b0, 1); chk("br_no_stall", s0, 0); next();
        ex_branch_taken = 1'b0;
        id_nop();
        mid(); chk("br_flush_1cyc", f0, 0); chk("br_cnt", c0, 0); next();

        // 4. MEM_LAT=3 store: two freeze cycles, branch held until free
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);          // sw
        mid(); chk("sw_c0_frz", z1, 0); next();
        id_nop();
        mid(); chk("sw_c1_frz", z1, 0); next();
        ex_branch_taken = 1'b1;
        mid(); chk("sw_frz1", z1, 1); chk("sw_frz1_noflush", f1, 0); next();
        mid(); chk("sw_frz2", z1, 1); chk("sw_frz2_noflush", f1, 0); next();
        mid(); chk("sw_frz_end", z1, 0); chk("sw_late_flush", f1, 1); chk("sw_cnt", c1, 2); next();
        ex_branch_taken = 1'b0;
        mid(); chk("sw_lat1_nofrz", z0, 0); next();

        // 4b. reset in the second freeze cycle
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        mid(); next();
        id_nop();
        mid(); next();
        mid(); chk("rw_frz1", z1, 1); next();
        reset = 1'b1;
        mid(); chk("rw_rst_cycle", z1, 0); next();
        reset = 1'b0;
        mid(); chk("rw_after", z1, 0); chk("rw_cnt", c1, 0); next();

        // 5. interlock: three stall cycles, then x0 producer never stalls
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);          // add x5
        mid(); next();
        set_id(1'b1, 5, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);          // or x8,x5,x2
        mid(); chk("il_stall1", s2, 1); next();
        mid(); chk("il_stall2", s2, 1); next();
        mid(); chk("il_stall3", s2, 1); next();
        mid(); chk("il_go", s2, 0); next();
        id_nop();
        mid(); chk("il_cnt", c2, 3); chk("il_fwd_a", fa2, 0); chk("il_fwd_b", fb2, 0); next();
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);          // add x0
        mid(); next();
        set_id(1'b1, 0, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);          // or x8,x0,x2
        mid(); chk("x0_no_stall", s2, 0); next();
        set_id(1'b0, 5, 5, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);          // invalid ID
        mid(); chk("x0_no_stall2", s2, 0); next();
        id_nop();
        mid(); chk("x0_cnt", c2, 0); next();

        // 6. 4-bit counter saturates at 15 (7 pairs x 3 stalls = 21)
        do_reset();
        for (int p = 0; p < 7; p++) begin
            set_id(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
            next();
            set_id(1'b1, 5, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) next();
            if (p == 3) chk("sat_mid", c2, 12);
        end
        id_nop();
        mid(); chk("sat_15", c2, 15); next();
        mid(); chk("sat_hold", c2, 15); next();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
